// File: rtl/spi_accel_pkg.sv
// Shared types and constants for the accelerometer SPI slave emulation.
// FSM states, command bytes and the fixed register addresses.
package spi_accel_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    WDATA,
    RDATA,
    IGNORE
  } state_t;

  localparam logic [7:0] CMD_WRITE = 8'h0A;
  localparam logic [7:0] CMD_READ  = 8'h0B;

  localparam logic [7:0] ADDR_DEVID_AD  = 8'h00;
  localparam logic [7:0] ADDR_DEVID_MST = 8'h01;
  localparam logic [7:0] ADDR_PARTID    = 8'h02;
  localparam logic [7:0] ADDR_XDATA     = 8'h08;
  localparam logic [7:0] ADDR_YDATA     = 8'h09;
  localparam logic [7:0] ADDR_ZDATA     = 8'h0A;
  localparam logic [7:0] ADDR_STATUS    = 8'h0B;
  localparam logic [7:0] ADDR_POWER_CTL = 8'h2D;

  function automatic logic is_read_only(input logic [7:0] a);
    return (a <= ADDR_PARTID) || ((a >= ADDR_XDATA) && (a <= ADDR_STATUS));
  endfunction

endpackage

// File: rtl/spi_accel_slave_sync.sv
// Synchroniser for SCLK/MOSI/CS_N with registered edge pulses for SCLK and CS_N.
// Chip select resets high so that leaving reset never looks like a select edge.
module spi_pin_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic sclk,
  input  logic mosi,
  input  logic cs_n,
  output logic mosi_s,
  output logic sclk_rise,
  output logic sclk_fall,
  output logic cs_fall,
  output logic cs_rise
);

  logic [SYNC_STAGES-1:0] sclk_sr;
  logic [SYNC_STAGES-1:0] mosi_sr;
  logic [SYNC_STAGES-1:0] cs_sr;
  logic                   sclk_prev;
  logic                   cs_prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sr   <= '0;
      mosi_sr   <= '0;
      cs_sr     <= '1;
      sclk_prev <= 1'b0;
      cs_prev   <= 1'b1;
      sclk_rise <= 1'b0;
      sclk_fall <= 1'b0;
      cs_fall   <= 1'b0;
      cs_rise   <= 1'b0;
    end else begin
      sclk_sr   <= {sclk_sr[SYNC_STAGES-2:0], sclk};
      mosi_sr   <= {mosi_sr[SYNC_STAGES-2:0], mosi};
      cs_sr     <= {cs_sr[SYNC_STAGES-2:0], cs_n};
      sclk_prev <= sclk_sr[SYNC_STAGES-1];
      cs_prev   <= cs_sr[SYNC_STAGES-1];
      sclk_rise <= sclk_sr[SYNC_STAGES-1] & ~sclk_prev;
      sclk_fall <= ~sclk_sr[SYNC_STAGES-1] & sclk_prev;
      cs_rise   <= cs_sr[SYNC_STAGES-1] & ~cs_prev;
      cs_fall   <= ~cs_sr[SYNC_STAGES-1] & cs_prev;
    end
  end

  assign mosi_s = mosi_sr[SYNC_STAGES-1];

endmodule

// File: rtl/spi_accel_slave.sv
// Mode-0 SPI slave presenting the accelerometer register map, oversampled in HCLK.
// Command byte, address byte, then auto-incrementing data bytes until CS_N rises.
module spi_accel_slave
  import spi_accel_pkg::*;
#(
  parameter int unsigned ADDR_W      = 6,
  parameter logic [7:0]  DEVID_AD    = 8'hAD,
  parameter logic [7:0]  DEVID_MST   = 8'h1D,
  parameter logic [7:0]  PARTID      = 8'hF2,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       HCLK,
  input  logic       HRESET,
  input  logic       SCLK,
  input  logic       MOSI,
  input  logic       CS_N,
  output logic       MISO,
  output logic       MISO_OE,
  input  logic [7:0] XDATA,
  input  logic [7:0] YDATA,
  input  logic [7:0] ZDATA,
  input  logic       SAMPLE_VALID,
  output logic [7:0] POWER_CTL
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic              mosi_s, sclk_rise, sclk_fall, cs_fall, cs_rise;
  state_t            state, next_state;
  logic [2:0]        bit_cnt;
  logic [6:0]        shift_in;
  logic [6:0]        shift_out;
  logic [ADDR_W-1:0] ptr;
  logic [7:0]        ptr8;
  logic              rd_mode;
  logic              data_ready;
  logic [7:0]        x_snap, y_snap, z_snap;
  logic [7:0]        mem [DEPTH];
  logic [7:0]        rx_byte;
  logic [7:0]        rd_data;
  logic              byte_done;
  logic              status_clear;

  spi_pin_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk      (HCLK),
    .rst      (HRESET),
    .sclk     (SCLK),
    .mosi     (MOSI),
    .cs_n     (CS_N),
    .mosi_s   (mosi_s),
    .sclk_rise(sclk_rise),
    .sclk_fall(sclk_fall),
    .cs_fall  (cs_fall),
    .cs_rise  (cs_rise)
  );

  assign ptr8         = 8'(ptr);
  assign rx_byte      = {shift_in, mosi_s};
  assign byte_done    = sclk_rise && (bit_cnt == 3'd7);
  assign status_clear = (state == RDATA) && byte_done && (ptr8 == ADDR_STATUS);

  always_comb begin
    rd_data = mem[ptr];
    case (ptr8)
      ADDR_DEVID_AD:  rd_data = DEVID_AD;
      ADDR_DEVID_MST: rd_data = DEVID_MST;
      ADDR_PARTID:    rd_data = PARTID;
      ADDR_XDATA:     rd_data = x_snap;
      ADDR_YDATA:     rd_data = y_snap;
      ADDR_ZDATA:     rd_data = z_snap;
      ADDR_STATUS:    rd_data = {7'b0, data_ready};
      ADDR_POWER_CTL: rd_data = POWER_CTL;
      default:        rd_data = mem[ptr];
    endcase
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:  if (cs_fall) next_state = CMD;
      CMD:   if (byte_done)
               next_state = ((rx_byte == CMD_WRITE) || (rx_byte == CMD_READ)) ? ADDR : IGNORE;
      ADDR:  if (byte_done) next_state = rd_mode ? RDATA : WDATA;
      default: next_state = state;
    endcase
    if (cs_rise) next_state = IDLE;
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      bit_cnt    <= '0;
      shift_in   <= '0;
      shift_out  <= '0;
      ptr        <= '0;
      rd_mode    <= 1'b0;
      data_ready <= 1'b0;
      x_snap     <= '0;
      y_snap     <= '0;
      z_snap     <= '0;
      POWER_CTL  <= '0;
      MISO       <= 1'b0;
      MISO_OE    <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[ADDR_W'(i)] <= '0;
    end else begin
      if (cs_fall) begin
        x_snap <= XDATA;
        y_snap <= YDATA;
        z_snap <= ZDATA;
      end

      // set has priority over the clear from a STATUS read
      if (SAMPLE_VALID)      data_ready <= 1'b1;
      else if (status_clear) data_ready <= 1'b0;

      if (cs_rise) begin
        bit_cnt <= '0;
      end else begin
        if ((state == IDLE) && cs_fall) begin
          bit_cnt <= '0;
        end else if (sclk_rise && (state inside {CMD, ADDR, WDATA, RDATA})) begin
          bit_cnt  <= bit_cnt + 3'd1;
          shift_in <= rx_byte[6:0];
        end

        if (byte_done) begin
          case (state)
            CMD:   rd_mode <= (rx_byte == CMD_READ);
            ADDR:  ptr <= rx_byte[ADDR_W-1:0];
            WDATA: begin
              if (ptr8 == ADDR_POWER_CTL)  POWER_CTL <= rx_byte;
              else if (!is_read_only(ptr8)) mem[ptr] <= rx_byte;
              ptr <= ptr + ADDR_W'(1);
            end
            RDATA: ptr <= ptr + ADDR_W'(1);
            default: ;
          endcase
        end

        // bit_cnt is 0 on the first fall of each data byte: load, else shift
        if ((state == RDATA) && sclk_fall) begin
          if (bit_cnt == 3'd0) begin
            MISO      <= rd_data[7];
            shift_out <= rd_data[6:0];
          end else begin
            MISO      <= shift_out[6];
            shift_out <= {shift_out[5:0], 1'b0};
          end
        end
      end

      MISO_OE <= (next_state == RDATA);
      if (next_state != RDATA) MISO <= 1'b0;
    end
  end

endmodule

// File: tb/tb_spi_accel_slave.sv
// Randomised bench for spi_accel_slave against a register-map model of the sensor.
module tb_spi_accel_slave;

  localparam int HALF = 6;

  logic       HCLK, HRESET, SCLK, MOSI, CS_N;
  logic       MISO, MISO_OE;
  logic [7:0] XDATA, YDATA, ZDATA;
  logic       SAMPLE_VALID;
  logic [7:0] POWER_CTL;

  int total = 0;
  int bad   = 0;

  logic [7:0] m_mem [64];
  logic [7:0] m_pwr;
  logic       m_dr;
  logic [7:0] m_snap [3];
  int         m_ptr;

  spi_accel_slave #(
    .ADDR_W(6), .DEVID_AD(8'hAD), .DEVID_MST(8'h1D), .PARTID(8'hF2), .SYNC_STAGES(2)
  ) dut (
    .HCLK(HCLK), .HRESET(HRESET), .SCLK(SCLK), .MOSI(MOSI), .CS_N(CS_N),
    .MISO(MISO), .MISO_OE(MISO_OE), .XDATA(XDATA), .YDATA(YDATA), .ZDATA(ZDATA),
    .SAMPLE_VALID(SAMPLE_VALID), .POWER_CTL(POWER_CTL)
  );

  initial begin
    HCLK = 1'b0;
    forever #5 HCLK = ~HCLK;
  end

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%02h exp=%02h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] m_read(input int a);
    case (a)
      0:       return 8'hAD;
      1:       return 8'h1D;
      2:       return 8'hF2;
      8:       return m_snap[0];
      9:       return m_snap[1];
      10:      return m_snap[2];
      11:      return {7'b0, m_dr};
      45:      return m_pwr;
      default: return m_mem[a];
    endcase
  endfunction

  task automatic m_write(input int a, input logic [7:0] d);
    if (a <= 2 || (a >= 8 && a <= 11)) return;
    if (a == 45) m_pwr = d;
    else         m_mem[a] = d;
  endtask

  task automatic m_reset();
    for (int i = 0; i < 64; i++) m_mem[i] = 8'h00;
    m_pwr = 8'h00;
    m_dr  = 1'b0;
    for (int i = 0; i < 3; i++) m_snap[i] = 8'h00;
    m_ptr = 0;
  endtask

  task automatic xfer(input logic [7:0] tx, input int nbits,
                      output logic [7:0] rx, output logic [7:0] oe);
    rx = '0;
    oe = '0;
    for (int i = 0; i < nbits; i++) begin
      MOSI = tx[7-i];
      repeat (HALF) @(negedge HCLK);
      rx[7-i] = MISO;
      oe[7-i] = MISO_OE;
      SCLK = 1'b1;
      repeat (HALF) @(negedge HCLK);
      SCLK = 1'b0;
    end
  endtask

  task automatic cs_low();
    CS_N = 1'b0;
    m_snap[0] = XDATA;
    m_snap[1] = YDATA;
    m_snap[2] = ZDATA;
    repeat (HALF) @(negedge HCLK);
  endtask

  task automatic txn_open(input logic [7:0] cmd, input logic [7:0] ab);
    logic [7:0] rx, oe;
    cs_low();
    xfer(cmd, 8, rx, oe);
    check("oe_cmd", oe, 8'h00);
    xfer(ab, 8, rx, oe);
    check("oe_addr", oe, 8'h00);
    m_ptr = int'(ab) & 63;
  endtask

  task automatic txn_close();
    repeat (HALF) @(negedge HCLK);
    CS_N = 1'b1;
    repeat (HALF + 2) @(negedge HCLK);
    check("oe_idle", 8'(MISO_OE), 8'h00);
    check("miso_idle", 8'(MISO), 8'h00);
  endtask

  task automatic rd_byte(input string tag);
    logic [7:0] rx, oe, exp;
    exp = m_read(m_ptr);
    xfer(8'h00, 8, rx, oe);
    check(tag, rx, exp);
    check("oe_data", oe, 8'hFF);
    if (m_ptr == 11) m_dr = 1'b0;
    m_ptr = (m_ptr + 1) & 63;
  endtask

  task automatic wr_byte(input logic [7:0] d);
    logic [7:0] rx, oe;
    xfer(d, 8, rx, oe);
    m_write(m_ptr, d);
    m_ptr = (m_ptr + 1) & 63;
  endtask

  task automatic pulse_sv(input logic [7:0] x, input logic [7:0] y, input logic [7:0] z);
    @(negedge HCLK);
    XDATA = x; YDATA = y; ZDATA = z;
    SAMPLE_VALID = 1'b1;
    @(negedge HCLK);
    SAMPLE_VALID = 1'b0;
    m_dr = 1'b1;
  endtask

  task automatic read_burst(input logic [7:0] ab, input int n, input string tag);
    txn_open(8'h0B, ab);
    for (int i = 0; i < n; i++) rd_byte(tag);
    txn_close();
  endtask

  initial begin
    logic [7:0] rx, oe, a;
    int n;
    HRESET = 1'b1; SCLK = 1'b0; MOSI = 1'b0; CS_N = 1'b1;
    XDATA = '0; YDATA = '0; ZDATA = '0; SAMPLE_VALID = 1'b0;
    m_reset();
    repeat (4) @(negedge HCLK);
    check("rst_miso", 8'(MISO), 8'h00);
    check("rst_oe", 8'(MISO_OE), 8'h00);
    check("rst_pwr", POWER_CTL, 8'h00);
    HRESET = 1'b0;
    repeat (4) @(negedge HCLK);

    read_burst(8'h00, 3, "id");

    txn_open(8'h0A, 8'h2D);
    wr_byte(8'h02);
    repeat (2) @(negedge HCLK);
    check("pwr_wr", POWER_CTL, m_pwr);
    txn_close();
    read_burst(8'h2D, 1, "pwr_rd");

    pulse_sv(8'h11, 8'h22, 8'h33);
    txn_open(8'h0B, 8'h08);
    XDATA = 8'h44;
    for (int i = 0; i < 4; i++) rd_byte("snap");
    pulse_sv(8'h44, 8'h22, 8'h33);
    txn_close();
    read_burst(8'h0B, 1, "stat_set");
    read_burst(8'h0B, 1, "stat_clr");

    txn_open(8'h0A, 8'h3F);
    wr_byte(8'h5A);
    wr_byte(8'h77);
    txn_close();
    read_burst(8'h3F, 2, "wrap");

    txn_open(8'h0A, 8'h20);
    wr_byte(8'hFF);
    txn_close();
    txn_open(8'h0A, 8'h20);
    xfer(8'h00, 5, rx, oe);
    txn_close();
    read_burst(8'h20, 1, "abort");

    cs_low();
    for (int i = 0; i < 3; i++) begin
      xfer((i == 0) ? 8'h0D : 8'h00, 8, rx, oe);
      check("ign_oe", oe, 8'h00);
      check("ign_miso", rx, 8'h00);
    end
    txn_close();

    for (int t = 0; t < 25; t++) begin
      case ($urandom_range(0, 2))
        0: pulse_sv(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                    8'($urandom_range(0, 255)));
        1: begin
          a = 8'($urandom_range(0, 255));
          if ($urandom_range(0, 3) == 0) a = 8'h2D;
          n = int'($urandom_range(1, 3));
          txn_open(8'h0A, a);
          for (int i = 0; i < n; i++) wr_byte(8'($urandom_range(0, 255)));
          txn_close();
          check("rnd_pwr", POWER_CTL, m_pwr);
        end
        default: begin
          a = 8'($urandom_range(0, 255));
          n = int'($urandom_range(1, 4));
          read_burst(a, n, "rnd_rd");
        end
      endcase
    end

    txn_open(8'h0A, 8'h2D);
    wr_byte(8'h08);
    txn_close();
    txn_open(8'h0B, 8'h00);
    xfer(8'h00, 2, rx, oe);
    repeat (HALF) @(negedge HCLK);
    a = m_read(0);
    check("pre_rst_miso", 8'(MISO), 8'(a[5]));
    check("pre_rst_oe", 8'(MISO_OE), 8'h01);
    check("pre_rst_pwr", POWER_CTL, 8'h08);
    #1 HRESET = 1'b1;
    #1;
    check("async_miso", 8'(MISO), 8'h00);
    check("async_oe", 8'(MISO_OE), 8'h00);
    check("async_pwr", POWER_CTL, 8'h00);
    CS_N = 1'b1;
    SCLK = 1'b0;
    m_reset();
    repeat (4) @(negedge HCLK);
    HRESET = 1'b0;
    repeat (4) @(negedge HCLK);
    read_burst(8'h20, 1, "post_rst_mem");
    read_burst(8'h2D, 1, "post_rst_pwr");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
